mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-interface sequencer directly upstream of the MDR stage.
- Takes read/write requests from the control unit, drives the RAM port with a programmable minimum wait-state count plus a ready handshake, and latches read data.
- Delivers the latched word as mdata_in, and pulses MDR_read/mdr_in so the MDR loads it in one clock.
- Write data is taken from the MDR output (Q).

Parameters:
ADDR_W, 9, width of memory address taken from MAR.
WAIT_CYCLES, 2, minimum cycles mem_rd/mem_wr held before mem_ready is sampled (0..15).
TIMEOUT, 16, cycles in WAIT after minimum expires before abort (used only with MEM_TIMEOUT_EN).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_read  input  1  control unit read request, sampled in IDLE.
req_write  input  1  control unit write request, sampled in IDLE.
addr  input  ADDR_W  address from MAR.
wdata  input  32  write data from MDR Q.
mem_rdata  input  32  RAM read data.
mem_ready  input  1  RAM completion handshake.
mem_addr  output  ADDR_W  registered RAM address.
mem_wdata  output  32  registered RAM write data.
mem_rd  output  1  RAM read strobe.
mem_wr  output  1  RAM write strobe.
mdata_in  output  32  latched read word to MDR mux.
MDR_read  output  1  MDR mux select (1 = mdata_in).
mdr_in  output  1  MDR load enable.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
err  output  1  sticky timeout flag (tied 0 without MEM_TIMEOUT_EN).

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs 0, including mem_addr, mem_wdata and mdata_in.
  - Wait counter = 0.
  - Reset asserted mid-transfer aborts immediately; strobes drop without waiting for a clock.
- IDLE:
  - req_read = 1 -> latch addr into mem_addr; go to ACCESS with op = read.
  - req_write = 1 (and req_read = 0) -> latch addr and wdata; go to ACCESS with op = write.
  - Both requests high -> read wins; the write is ignored, not queued.
- ACCESS:
  - mem_rd or mem_wr = 1 and held through WAIT.
  - Counter loads WAIT_CYCLES.
  - Next state is WAIT; if WAIT_CYCLES = 0, WAIT samples mem_ready on its first cycle.
- WAIT:
  - Strobe held.
  - Counter decrements to 0.
  - Once the counter is 0 and mem_ready = 1: drop the strobe.
    - Read: mdata_in <= mem_rdata on that edge; next state CAPTURE.
    - Write: next state FINISH.
  - mem_ready asserted while counter > 0 is ignored.
- CAPTURE (read only, one cycle):
  - MDR_read = 1 and mdr_in = 1, so the MDR loads mdata_in on the next edge.
  - Next state FINISH.
- FINISH (one cycle):
  - done = 1; MDR_read and mdr_in = 0.
  - Next state IDLE.
  - Requests are not accepted until back in IDLE.
- Latency:
  - Read request to done = WAIT_CYCLES + 4 cycles when mem_ready is already high.
  - Write request to done = WAIT_CYCLES + 3 cycles when mem_ready is already high.
- Request changes after acceptance have no effect.
- mdata_in holds its value until the next read capture.
- busy = 1 in ACCESS, WAIT, CAPTURE and FINISH.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - After the WAIT counter reaches 0, a second counter counts cycles without mem_ready.
  - When the count reaches TIMEOUT: drop the strobe, set err = 1, skip CAPTURE, go to FINISH (done pulses; the MDR is not loaded).
  - err clears only on reset.
- Undefined: WAIT waits indefinitely; err is constant 0.

Test Plan:
- Reset check: hold reset = 0, toggle clock, apply random inputs -> all outputs 0 and busy = 0; release reset -> IDLE.
- Read, WAIT_CYCLES = 2, addr = 0x05A, mem_rdata = 0xDEADBEEF, mem_ready tied 1:
  - mem_rd high exactly 3 cycles.
  - mdata_in = 0xDEADBEEF.
  - MDR_read = mdr_in = 1 for one cycle.
  - done pulses 6 cycles after req_read.
- Write, wdata = 0x12345678, addr = 0x1FF:
  - mem_wr asserted with mem_wdata = 0x12345678 and mem_addr = 0x1FF.
  - mdr_in never asserts.
  - done pulses 5 cycles after req_write.
- Ready handshake: mem_ready held 0 for 5 extra cycles -> mem_rd extends accordingly; mdata_in is captured only on the mem_ready edge; an early mem_ready during the counter is ignored.
- Simultaneous req_read = req_write = 1 -> read is performed; mem_wr stays 0; the request raised again during busy is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT = 16, mem_ready stuck 0:
  - err = 1 after WAIT_CYCLES + 16 WAIT cycles.
  - done pulses, mdr_in stays 0.
  - Reset mid-WAIT drops mem_rd immediately.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer between the control unit and RAM: minimum wait-state strobe,
// ready handshake, read-data capture and a one-cycle MDR load. Optional stall abort: MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mdata_in,
  output logic              MDR_read,
  output logic              mdr_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state    | meaning
  // IDLE     | waiting for a request
  // ACCESS   | strobe raised, address/data stable
  // WAIT     | strobe held until min wait expires and mem_ready
  // CAPTURE  | read word presented to MDR, MDR loads
  // FINISH   | done pulse, back to IDLE

  if (WAIT_CYCLES > 15 || TIMEOUT == 0) begin : g_param_check
    $error("mem_access_ctrl: WAIT_CYCLES must be 0..15 and TIMEOUT nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_op_rd;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              w_min_done;
  logic              w_complete;
  logic              w_timeout;
  logic              w_strobe;

  assign w_min_done = (r_cnt == 4'd0);
  assign w_complete = (r_state == S_WAIT) && w_min_done && mem_ready;

  // The counter is loaded on acceptance and already counts during ACCESS, so the
  // strobe is held WAIT_CYCLES+1 cycles minimum and WAIT_CYCLES=0 samples ready at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op_rd <= 1'b0;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_read) begin
            r_addr  <= addr;
            r_op_rd <= 1'b1;
            r_cnt   <= 4'(WAIT_CYCLES);
          end else if (req_write) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_op_rd <= 1'b0;
            r_cnt   <= 4'(WAIT_CYCLES);
          end
        end
        S_ACCESS, S_WAIT: begin
          if (!w_min_done) r_cnt <= r_cnt - 4'd1;
        end
        default: ;
      endcase
      if (w_complete && r_op_rd) r_rdata <= mem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to;

  assign w_timeout = (r_state == S_WAIT) && w_min_done && !mem_ready
                     && (r_to == TO_W'(TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_to <= '0;
      else if (w_min_done && !mem_ready && !w_timeout) r_to <= r_to + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign r_err     = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_strobe = 1'b0;
    MDR_read = 1'b0;
    mdr_in   = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req_read || req_write) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_strobe = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        w_strobe = 1'b1;
        if (w_complete) w_next = r_op_rd ? S_CAPTURE : S_FINISH;
        else if (w_timeout) w_next = S_FINISH;
      end
      S_CAPTURE: begin
        MDR_read = 1'b1;
        mdr_in   = 1'b1;
        w_next   = S_FINISH;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_rd    = w_strobe && r_op_rd;
  assign mem_wr    = w_strobe && !r_op_rd;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mdata_in  = r_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table of transactions with a
// scoreboard queue, plus hand sequences for reset, stalls and mid-transfer reset.
module tb_mem_access_ctrl;

  logic        clock;
  logic        reset;
  logic        req_read;
  logic        req_write;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mdata_in;
  logic        MDR_read;
  logic        mdr_in;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.ADDR_W(9), .WAIT_CYCLES(2), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mdata_in(mdata_in), .MDR_read(MDR_read), .mdr_in(mdr_in), .busy(busy),
    .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // op: 0 read, 1 write, 2 both requests together
  typedef struct {
    int          op;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ready_at;
    bit          early;
    bit          raise;
    int          exp_rd;
    int          exp_wr;
    int          exp_done;
    int          exp_mdr;
    logic [31:0] exp_mdata;
  } vec_t;

  typedef struct {
    int          rd;
    int          wr;
    int          done_at;
    int          mdr;
    logic [31:0] mdata;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int c);
    logic hit;
    hit       = (v.raise && (c == 3 || c == 4));
    req_read  = ((c == 1) && (v.op != 1)) || hit;
    req_write = ((c == 1) && (v.op != 0)) || hit;
    addr      = (c == 1) ? v.a : ~v.a;
    wdata     = (c == 1) ? v.wd : ~v.wd;
    mem_ready = (c >= v.ready_at) || (v.early && (c == 2 || c == 3));
    mem_rdata = (c >= v.ready_at) ? v.rd : (v.rd ^ 32'hFFFF_0000 ^ 32'(c));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t x;
    int c, rd_n, wr_n, mdr_n, sel_n, addr_bad, wd_bad, cap_bad, busy_bad, done_at;
    bit got;
    e.rd = v.exp_rd; e.wr = v.exp_wr; e.done_at = v.exp_done;
    e.mdr = v.exp_mdr; e.mdata = v.exp_mdata;
    sb_q.push_back(e);
    rd_n = 0; wr_n = 0; mdr_n = 0; sel_n = 0;
    addr_bad = 0; wd_bad = 0; cap_bad = 0; busy_bad = 0; done_at = 0; got = 0;
    @(posedge clock); #1;
    c = 1;
    drive(v, c);
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clock);
      if (mem_rd) rd_n++;
      if (mem_wr) begin
        wr_n++;
        if (mem_wdata !== v.wd) wd_bad++;
      end
      if ((mem_rd || mem_wr) && mem_addr !== v.a) addr_bad++;
      if (mdr_in) begin
        mdr_n++;
        if (mdata_in !== v.exp_mdata) cap_bad++;
      end
      if (MDR_read) sel_n++;
      if (c > 1 && !busy) busy_bad++;
      if (done) begin
        got = 1;
        done_at = c;
      end else begin
        @(posedge clock); #1;
        c++;
        drive(v, c);
      end
    end
    check($sformatf("v%0d_done_seen", idx), got, 1);
    x = sb_q.pop_front();
    check($sformatf("v%0d_rd_cycles", idx), rd_n, x.rd);
    check($sformatf("v%0d_wr_cycles", idx), wr_n, x.wr);
    check($sformatf("v%0d_done_latency", idx), done_at, x.done_at);
    check($sformatf("v%0d_mdr_in", idx), mdr_n, x.mdr);
    check($sformatf("v%0d_MDR_read", idx), sel_n, x.mdr);
    check($sformatf("v%0d_mdata_in", idx), mdata_in, x.mdata);
    check($sformatf("v%0d_addr_bad", idx), addr_bad, 0);
    check($sformatf("v%0d_wdata_bad", idx), wd_bad, 0);
    check($sformatf("v%0d_capture_bad", idx), cap_bad, 0);
    check($sformatf("v%0d_busy_bad", idx), busy_bad, 0);
    check($sformatf("v%0d_err", idx), err, 0);
    @(posedge clock); #1;
    req_read = 0; req_write = 0; mem_ready = 1'b1;
    @(negedge clock);
    check($sformatf("v%0d_post_busy", idx), busy, 0);
    check($sformatf("v%0d_post_done", idx), done, 0);
  endtask

  task automatic reset_check();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      req_read  = 1'($urandom);
      req_write = 1'($urandom);
      addr      = 9'($urandom);
      wdata     = $urandom;
      mem_rdata = $urandom;
      mem_ready = 1'($urandom);
      @(negedge clock);
      check("rst_data", {mem_wdata, mdata_in}, 64'd0);
      check("rst_ctl", {mem_addr, mem_rd, mem_wr, MDR_read, mdr_in, busy, done, err}, 64'd0);
    end
    @(posedge clock); #1;
    req_read = 0; req_write = 0; mem_ready = 1'b1; mem_rdata = '0;
    reset = 1'b1;
    @(negedge clock);
    check("rst_release_busy", busy, 0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic timeout_seq();
    int c, mdr_n;
    bit got;
    mdr_n = 0; got = 0;
    @(posedge clock); #1;
    req_read = 1'b1; addr = 9'h033; mem_ready = 1'b0; mem_rdata = 32'h5555_AAAA;
    c = 1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clock);
      if (mdr_in) mdr_n++;
      if (done) begin
        got = 1;
        check("to_latency", c, 21);
        check("to_err", err, 1);
      end else begin
        @(posedge clock); #1;
        req_read = 1'b0;
        c++;
      end
    end
    check("to_done_seen", got, 1);
    check("to_mdr", mdr_n, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("to_err_sticky", err, 1);
    reset = 1'b0;
    #2;
    check("to_err_clear", err, 0);
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b1;
  endtask
`endif

  task automatic stall_reset_seq();
    @(posedge clock); #1;
    req_read = 1'b1; addr = 9'h0C3; mem_ready = 1'b0; mem_rdata = 32'h7777_8888;
    @(posedge clock); #1;
    req_read = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("stall_rd_held", mem_rd, 1);
    check("stall_err", err, 0);
    check("stall_mdata_kept", mdata_in, 32'h0000_0001);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_rd_drop", mem_rd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mdata", mdata_in, 0);
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    check("midrst_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b0; req_read = 0; req_write = 0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b1;

    vecs[0] = '{0, 9'h05A, 32'h0,         32'hDEADBEEF, 1, 0, 0, 3, 0, 6, 1, 32'hDEADBEEF};
    vecs[1] = '{1, 9'h1FF, 32'h12345678,  32'h0,        1, 0, 0, 0, 3, 5, 0, 32'hDEADBEEF};
    vecs[2] = '{0, 9'h100, 32'h0,         32'hCAFEF00D, 9, 1, 0, 8, 0, 11, 1, 32'hCAFEF00D};
    vecs[3] = '{2, 9'h0A5, 32'hFFFF0000,  32'h0BADC0DE, 1, 0, 1, 3, 0, 6, 1, 32'h0BADC0DE};
    vecs[4] = '{1, 9'h000, 32'hA5A5A5A5,  32'h0,        7, 0, 0, 0, 6, 8, 0, 32'h0BADC0DE};
    vecs[5] = '{0, 9'h1FE, 32'h0,         32'h00000001, 5, 0, 0, 4, 0, 7, 1, 32'h00000001};

    reset_check();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    stall_reset_seq();
`ifdef MEM_TIMEOUT_EN
    timeout_seq();
`endif
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
